// File: rtl/tone_sequencer.sv
// Note-table sequencer: fetches {freq, dur} entries and drives a registered
// freq word for the phase generator, with per-note timing, gaps and looping.
module tone_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FREQ_W   = 13,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [FREQ_W-1:0]        wr_freq,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic [3:0]               gap_ticks,
  output logic [FREQ_W-1:0]        freq,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     note_strobe,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned EW = FREQ_W + DUR_W;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [EW-1:0]     tbl_mem [DEPTH];
  logic [EW-1:0]     rd_q;
  logic [FREQ_W-1:0] rd_freq;
  logic [DUR_W-1:0]  rd_dur;

  logic [1:0]        state_q,  state_d;
  logic [FREQ_W-1:0] freq_q,   freq_d;
  logic              busy_q,   busy_d;
  logic [AW-1:0]     idx_q,    idx_d;
  logic              strobe_q, strobe_d;
  logic              done_q,   done_d;
  logic [PW-1:0]     presc_q,  presc_d;
  logic [DUR_W-1:0]  dur_q,    dur_d;
  logic [3:0]        gap_q,    gap_d;

  logic tick;
  logic adv;
  logic fin;

  assign rd_freq = rd_q[EW-1:DUR_W];
  assign rd_dur  = rd_q[DUR_W-1:0];
  assign tick    = (presc_q == TICK_LAST);

  // Read address is the next note index, so the entry is ready during FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) tbl_mem[wr_addr] <= {wr_freq, wr_dur};
    rd_q <= tbl_mem[idx_d];
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    presc_d  = presc_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    adv      = 1'b0;
    fin      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_dur == '0) begin
          fin = 1'b1;
        end else begin
          freq_d   = rd_freq;
          dur_d    = rd_dur;
          strobe_d = 1'b1;
          presc_d  = '0;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          dur_d = dur_q - 1'b1;
          if (dur_q == DUR_W'(1)) begin
            if (gap_ticks != 4'd0) begin
              freq_d  = '0;
              gap_d   = gap_ticks;
              presc_d = '0;
              state_d = S_GAP;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      default: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == 4'd1) adv = 1'b1;
        end
      end
    endcase

    if (adv) begin
      if (idx_q == last_idx) begin
        if (loop_en) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          fin = 1'b1;
        end
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (fin) begin
      freq_d  = '0;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end

    // Stop overrides everything, including a start seen in the same cycle.
    if (stop) begin
      state_d  = S_IDLE;
      freq_d   = '0;
      idx_d    = idx_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      freq_q   <= '0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
    end
  end

  assign freq        = freq_q;
  assign busy        = busy_q;
  assign note_idx    = idx_q;
  assign note_strobe = strobe_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4: a cycle-exact vector
// table for a two-note play, plus sequences for gaps, looping, stop and end markers.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, start, stop, loop_en;
  logic [3:0]  wr_addr, last_idx, gap_ticks;
  logic [12:0] wr_freq;
  logic [7:0]  wr_dur;
  logic [12:0] freq;
  logic        busy, note_strobe, done;
  logic [3:0]  note_idx;

  int total = 0;
  int bad   = 0;

  int          done_at, n100, n200, nzb;
  logic [12:0] freq_at_done;
  logic [3:0]  sq_idx[$];
  logic [12:0] sq_freq[$];

  typedef struct {
    logic        start;
    logic        stop;
    logic [12:0] freq;
    logic        busy;
    logic [3:0]  idx;
    logic        strobe;
    logic        done;
  } vec_t;

  vec_t vt[18];

  tone_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop_en(loop_en), .last_idx(last_idx), .gap_ticks(gap_ticks),
    .freq(freq), .busy(busy), .note_idx(note_idx),
    .note_strobe(note_strobe), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_entry(input logic [3:0] a, input logic [12:0] f, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_dur = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Pulses start on cycle 0 (and optionally again at restart_cyc), optionally
  // writes one entry at wr_cyc, and samples outputs until done or maxc cycles.
  task automatic run(input int maxc, input int wr_cyc, input logic [3:0] wa,
                     input logic [12:0] wf, input logic [7:0] wd, input int restart_cyc);
    done_at = -1; n100 = 0; n200 = 0; nzb = 0; freq_at_done = 13'h1fff;
    sq_idx.delete(); sq_freq.delete();
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      start   = (c == 0) || (c == restart_cyc);
      wr_en   = (c == wr_cyc);
      wr_addr = wa; wr_freq = wf; wr_dur = wd;
      @(posedge clk);
      #1;
      if (freq == 13'd100) n100++;
      if (freq == 13'd200) n200++;
      if (busy && freq == 13'd0) nzb++;
      if (note_strobe) begin
        sq_idx.push_back(note_idx);
        sq_freq.push_back(freq);
      end
      if (done) begin
        done_at = c;
        freq_at_done = freq;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_addr = '0; wr_freq = '0; wr_dur = '0; last_idx = 4'd1; gap_ticks = 4'd0;

    // Vector table for the two-note play (e0={100,2}, e1={200,1}) then start+stop.
    vt[0] = '{1'b1, 1'b0, 13'd0, 1'b1, 4'd0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 13'd100, 1'b1, 4'd0, 1'b1, 1'b0};
    for (int i = 2; i <= 8; i++) vt[i] = '{1'b0, 1'b0, 13'd100, 1'b1, 4'd0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 13'd100, 1'b1, 4'd1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 13'd200, 1'b1, 4'd1, 1'b1, 1'b0};
    for (int i = 11; i <= 13; i++) vt[i] = '{1'b0, 1'b0, 13'd200, 1'b1, 4'd1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 13'd0, 1'b0, 4'd1, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 13'd0, 1'b0, 4'd1, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 13'd0, 1'b0, 4'd1, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 13'd0, 1'b0, 4'd1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_freq", int'(freq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_strobe", int'(note_strobe), 0);
    chk("rst_done", int'(done), 0);

    wr_entry(4'd0, 13'd100, 8'd2);
    wr_entry(4'd1, 13'd200, 8'd1);

    // Reset held mid-PLAY
    run(5, -1, 4'd0, 13'd0, 8'd0, -1);
    chk("pre_rst_freq", int'(freq), 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_freq", int'(freq), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_idx", int'(note_idx), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_busy", int'(busy), 0);

    // Table-driven two-note play
    for (int i = 0; i < 18; i++) begin
      logic [19:0] act, exp;
      @(negedge clk);
      start = vt[i].start;
      stop  = vt[i].stop;
      @(posedge clk);
      #1;
      act = {freq, busy, note_idx, note_strobe, done};
      exp = {vt[i].freq, vt[i].busy, vt[i].idx, vt[i].strobe, vt[i].done};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL vec[%0d]: got freq=%0d busy=%b idx=%0d strobe=%b done=%b expected freq=%0d busy=%b idx=%0d strobe=%b done=%b",
                 i, freq, busy, note_idx, note_strobe, done,
                 vt[i].freq, vt[i].busy, vt[i].idx, vt[i].strobe, vt[i].done);
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;

    // Gap of 2 ticks after each note
    gap_ticks = 4'd2;
    run(40, -1, 4'd0, 13'd0, 8'd0, -1);
    chk("gap_n100", n100, 8);
    chk("gap_n200", n200, 4);
    chk("gap_silent_busy", nzb, 18);
    chk("gap_strobes", sq_idx.size(), 2);
    chk("gap_done_at", done_at, 30);

    // Loop, then stop mid-note
    gap_ticks = 4'd0;
    loop_en   = 1'b1;
    run(40, -1, 4'd0, 13'd0, 8'd0, -1);
    chk("loop_no_done", done_at, -1);
    chk("loop_strobes", sq_idx.size(), 6);
    for (int i = 0; i < sq_idx.size() && i < 6; i++) begin
      chk($sformatf("loop_idx%0d", i), int'(sq_idx[i]), i % 2);
      chk($sformatf("loop_freq%0d", i), int'(sq_freq[i]), (i % 2 == 0) ? 100 : 200);
    end
    chk("loop_busy_before_stop", int'(busy), 1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    chk("stop_freq", int'(freq), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    @(negedge clk);
    stop = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_after_done", int'(done), 0);
    chk("stop_after_busy", int'(busy), 0);

    // End marker in e1 ends the sequence before last_idx
    loop_en  = 1'b0;
    last_idx = 4'd5;
    wr_entry(4'd1, 13'd200, 8'd0);
    run(40, -1, 4'd0, 13'd0, 8'd0, -1);
    chk("eos_done_at", done_at, 10);
    chk("eos_n100", n100, 9);
    chk("eos_strobes", sq_idx.size(), 1);
    chk("eos_freq_at_done", int'(freq_at_done), 0);
    chk("eos_idx", int'(note_idx), 1);

    // Full 16-entry table, live rewrite of e3, start while busy
    last_idx = 4'd15;
    for (int i = 0; i < 16; i++) wr_entry(4'(i), 13'((i + 1) * 10), 8'd1);
    run(100, 7, 4'd3, 13'd999, 8'd1, 20);
    chk("full_done_at", done_at, 80);
    chk("full_strobes", sq_idx.size(), 16);
    for (int i = 0; i < sq_idx.size() && i < 16; i++) begin
      chk($sformatf("full_idx%0d", i), int'(sq_idx[i]), i);
      chk($sformatf("full_freq%0d", i), int'(sq_freq[i]), (i == 3) ? 999 : (i + 1) * 10);
    end
    chk("full_end_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
